// File: rtl/uart_status_pkg.sv
// uart_status_pkg: shared types and constants for the status frame uplink
package uart_status_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH} state_t;
  localparam int FRAME_LEN = 5;
  localparam logic [7:0] ASCII_BASE = 8'h30;
  typedef struct packed {
    logic       ok;
    logic [2:0] gen_num;
    logic       updown;
    logic [7:0] periods;
  } report_t;
endpackage

// File: rtl/status_frame_slot.sv
// status_frame_slot: two-entry active/pending report buffer
// Ports: clk, rst_n (async, active low); push/rec = new report; pop = active frame done;
//        act_valid/act = record being sent; pend_valid = second record queued; drop = push rejected.
module status_frame_slot
  import uart_status_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  report_t rec,
  output logic    act_valid,
  output report_t act,
  output logic    pend_valid,
  output logic    drop
);
  report_t pend;
  logic    av_after, pv_after;
  report_t a_after;
  // Pop is applied first so a push on the completion edge sees the freed slot.
  assign av_after = pop ? pend_valid : act_valid;
  assign a_after  = pop ? pend : act;
  assign pv_after = pop ? 1'b0 : pend_valid;
  assign drop     = push && av_after && pv_after;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid  <= 1'b0;
      pend_valid <= 1'b0;
      act        <= '0;
      pend       <= '0;
    end else begin
      act_valid  <= av_after || push;
      act        <= (push && !av_after) ? rec : a_after;
      pend_valid <= pv_after || (push && av_after);
      pend       <= (push && av_after && !pv_after) ? rec : pend;
    end
  end
endmodule

// File: rtl/uart_status_reporter.sv
// uart_status_reporter: formats 5-byte phase-shift status frames and feeds them to the UART
// Ports: i_clk, i_rst_n (async, active low); i_report_req + i_ok/i_gen_num/i_phaseupdown/i_periods = report;
//        i_tx_ready/o_tx_data/o_tx_load = UART handshake; o_busy = frame active or pending;
//        o_drop_count = saturating count of rejected reports.
module uart_status_reporter
  import uart_status_pkg::*;
#(
  parameter logic [7:0] ACK_CHAR       = 8'h41,
  parameter logic [7:0] ERR_CHAR       = 8'h45,
  parameter logic [7:0] TERM_CHAR      = 8'h0A,
  parameter int         ACCEPT_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_report_req,
  input  logic       i_ok,
  input  logic [2:0] i_gen_num,
  input  logic       i_phaseupdown,
  input  logic [7:0] i_periods,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_load,
  output logic       o_busy,
  output logic [7:0] o_drop_count
);
  localparam int CW = $clog2(ACCEPT_TIMEOUT + 1);
  localparam logic [CW-1:0] T_LAST = CW'(ACCEPT_TIMEOUT - 1);
  localparam logic [2:0] I_LAST = 3'(FRAME_LEN - 1);
  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          act_valid, pend_valid, drop, done;
  report_t       act, rec;
  logic [7:0]    cur;
  assign rec  = '{ok: i_ok, gen_num: i_gen_num, updown: i_phaseupdown, periods: i_periods};
  assign done = (state == WAIT_HIGH) && i_tx_ready && (idx == I_LAST);
  assign cur  = (idx == 3'd0) ? (act.ok ? ACK_CHAR : ERR_CHAR) :
                (idx == 3'd1) ? ASCII_BASE + {5'd0, act.gen_num} :
                (idx == 3'd2) ? ASCII_BASE + {7'd0, act.updown} :
                (idx == 3'd3) ? act.periods : TERM_CHAR;
  assign o_busy = act_valid || pend_valid;
  status_frame_slot u_slot (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (i_report_req),
    .pop       (done),
    .rec       (rec),
    .act_valid (act_valid),
    .act       (act),
    .pend_valid(pend_valid),
    .drop      (drop)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cnt          <= '0;
      o_tx_data    <= '0;
      o_tx_load    <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_tx_load <= 1'b0;
      if (drop && o_drop_count != 8'hFF) o_drop_count <= o_drop_count + 8'd1;
      case (state)
        IDLE: if (i_report_req) begin
          idx   <= '0;
          state <= LOAD;
        end
        LOAD: if (i_tx_ready) begin
          o_tx_data <= cur;
          o_tx_load <= 1'b1;
          cnt       <= '0;
          state     <= WAIT_LOW;
        end
        // A UART that never lowers ready is assumed to have taken the byte after the timeout.
        WAIT_LOW: if (!i_tx_ready || cnt == T_LAST) state <= WAIT_HIGH;
          else cnt <= cnt + 1'b1;
        WAIT_HIGH: if (i_tx_ready) begin
          idx   <= (idx == I_LAST) ? 3'd0 : idx + 3'd1;
          state <= (idx != I_LAST || pend_valid || i_report_req) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_status_reporter.sv
// tb_uart_status_reporter: directed/random checks of the status frame uplink against a frame-queue model
module tb_uart_status_reporter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       ok = 1'b0;
  logic [2:0] gen = '0;
  logic       ud = 1'b0;
  logic [7:0] per = '0;
  logic       ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       busy;
  logic [7:0] drop_count;
  int errors = 0;
  int checks = 0;
  int mode = 0;
  int cyc = 0;
  int n_acc = 0;
  int model_drop = 0;
  logic prev_load = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int lt[$];

  uart_status_reporter dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_report_req (req),
    .i_ok         (ok),
    .i_gen_num    (gen),
    .i_phaseupdown(ud),
    .i_periods    (per),
    .i_tx_ready   (ready),
    .o_tx_data    (tx_data),
    .o_tx_load    (tx_load),
    .o_busy       (busy),
    .o_drop_count (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // UART model: mode 0 lowers ready one cycle after a load and restores it ten cycles later,
  // mode 1 keeps ready high forever, mode 2 holds ready low.
  initial begin
    forever begin
      @(posedge clk); #2;
      if (mode == 2) ready = 1'b0;
      else if (mode == 1) ready = 1'b1;
      else begin
        ready = 1'b1;
        if (tx_load) begin
          @(posedge clk); #2; ready = 1'b0;
          repeat (10) @(posedge clk);
          #2; ready = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_load) begin
        got.push_back(tx_data);
        lt.push_back(cyc);
        chk("load_width", {31'd0, prev_load}, 0);
      end
      prev_load = tx_load;
    end
  end

  task automatic issue(input logic o, input logic [2:0] g, input logic u, input logic [7:0] p);
    ok = o; gen = g; ud = u; per = p; req = 1'b1;
    if (n_acc - got.size() / 5 < 2) begin
      n_acc++;
      exp_q.push_back(o ? 8'h41 : 8'h45);
      exp_q.push_back(8'h30 + {5'd0, g});
      exp_q.push_back(8'h30 + {7'd0, u});
      exp_q.push_back(p);
      exp_q.push_back(8'h0A);
    end else if (model_drop < 255) model_drop++;
  endtask

  task automatic scramble();
    req = 1'b0; ok = 1'($urandom); gen = 3'($urandom); ud = 1'($urandom); per = 8'($urandom);
  endtask

  task automatic pulse(input logic o, input logic [2:0] g, input logic u, input logic [7:0] p);
    @(posedge clk); #1 issue(o, g, u, p);
    @(posedge clk); #1 scramble();
  endtask

  task automatic pulse_rand();
    pulse(1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); #1; n++; end
    chk("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic wait_bytes(input int n);
    int k = 0;
    while (got.size() < n && k < 3000) begin @(negedge clk); #1; k++; end
    chk("bytes_timeout", {31'd0, got.size() >= n}, 1);
  endtask

  task automatic compare(input string tag);
    wait_idle();
    repeat (2) @(negedge clk);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) chk({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
    chk({tag, "_drop"}, {24'd0, drop_count}, model_drop);
    got.delete(); exp_q.delete(); lt.delete(); n_acc = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", {24'd0, tx_data}, 0);
    chk("rst_load", {31'd0, tx_load}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_drop", {24'd0, drop_count}, 0);
    rst_n = 1'b1;
    // single frame, latency and first byte
    @(posedge clk); #1 issue(1'b1, 3'd3, 1'b0, 8'h05);
    @(posedge clk); #1 scramble();
    @(negedge clk); chk("t1_lat_early", {31'd0, tx_load}, 0);
    @(negedge clk); chk("t1_lat_load", {31'd0, tx_load}, 1);
    chk("t1_first", {24'd0, tx_data}, 32'h41);
    compare("t1");
    pulse(1'b0, 3'd7, 1'b1, 8'hFF);
    compare("t2");
    // three requests: one active, one pending, one dropped
    pulse_rand(); pulse_rand(); pulse_rand();
    wait_bytes(9);
    chk("t3_busy", {31'd0, busy}, 1);
    compare("t3");
    // UART never lowers ready: bytes advance on timeout
    mode = 1;
    pulse_rand();
    wait_idle();
    for (int i = 1; i < lt.size(); i++)
      chk("t4_gap", {31'd0, (lt[i] - lt[i-1] >= 16) && (lt[i] - lt[i-1] <= 20)}, 1);
    compare("t4");
    mode = 0;
    // reset while a load strobe is high
    pulse_rand();
    wait_bytes(3);
    chk("t5_load_before", {31'd0, tx_load}, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_load", {31'd0, tx_load}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_drop", {24'd0, drop_count}, 0);
    got.delete(); exp_q.delete(); lt.delete(); n_acc = 0; model_drop = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    pulse_rand();
    compare("t5");
    // request on the completion edge: next frame starts with no idle gap
    pulse_rand();
    wait_bytes(5);
    repeat (11) @(posedge clk);
    #1 issue(1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
    @(posedge clk); #1 scramble();
    @(negedge clk); chk("t6_nogap_busy", {31'd0, busy}, 1);
    @(negedge clk); chk("t6_nogap_load", {31'd0, tx_load}, 1);
    compare("t6a");
    // stalled UART, 300 back-to-back requests saturate the drop counter
    mode = 2;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1 issue(1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
    end
    @(posedge clk); #1 scramble();
    @(negedge clk);
    chk("t6_sat", {24'd0, drop_count}, 255);
    chk("t6_busy", {31'd0, busy}, 1);
    mode = 0;
    compare("t6b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_status_reporter.md
Name: uart_status_reporter

Overview:
Uplink half of the host phase-control link. Each time a phase shift finishes, the block formats a 5-byte status frame and feeds it byte-by-byte into the UART transmitter through its txDataIN/txLoadIN/txReadyOUT handshake. It sits alongside the receive-side command mapper and the phase shift processors, and closes the loop back to the host.

Parameters:
ACK_CHAR, 8'h41 ('A'), first frame byte when the shift completed OK
ERR_CHAR, 8'h45 ('E'), first frame byte when the shift is reported failed
TERM_CHAR, 8'h0A, last frame byte
ACCEPT_TIMEOUT, 16, cycles to wait for i_tx_ready to fall after a load before the byte is treated as accepted

Ports:
i_clk  in  1  system clock (50 MHz)
i_rst_n  in  1  asynchronous reset, active low
i_report_req  in  1  one-cycle pulse: a shift has completed; report fields are valid this cycle
i_ok  in  1  1 = success (ACK_CHAR), 0 = error (ERR_CHAR)
i_gen_num  in  3  generator index 0..7
i_phaseupdown  in  1  shift direction used
i_periods  in  8  shift count processed, as raw value
i_tx_ready  in  1  UART transmitter ready to accept a byte
o_tx_data  out  8  byte to UART (registered)
o_tx_load  out  1  one-cycle load strobe to UART (registered)
o_busy  out  1  high while a frame is active or pending
o_drop_count  out  8  saturating count of requests dropped for lack of buffer space

Behaviour:
- Reset (async, i_rst_n=0): o_tx_data=0, o_tx_load=0, o_busy=0, o_drop_count=0, state IDLE, active and pending slots empty. Reset mid-frame abandons the frame. o_tx_load drops immediately.
- Frame, byte 0..4: {i_ok ? ACK_CHAR : ERR_CHAR}, 8'h30+i_gen_num, 8'h30+i_phaseupdown, i_periods, TERM_CHAR. All fields are captured on the edge where i_report_req is sampled high. Later input changes do not affect the frame.
- Buffering: one active slot plus one pending slot.
  - Request while idle goes to active.
  - Request while active busy goes to pending if it is empty.
  - Otherwise the request is dropped and o_drop_count increments, saturating at 255.
- FSM:
  - IDLE -> LOAD when the active slot fills.
  - LOAD: on an edge with i_tx_ready=1, register o_tx_data=byte[idx] and o_tx_load=1, then go to WAIT_LOW. If i_tx_ready=0, stay in LOAD.
  - WAIT_LOW: o_tx_load is cleared at the next edge, so it is exactly 1 cycle wide. Go to WAIT_HIGH when i_tx_ready=0 is sampled, or when the timeout counter reaches ACCEPT_TIMEOUT.
  - WAIT_HIGH: when i_tx_ready=1, if idx<4 then idx++ and go to LOAD. If idx=4, the frame is done (DONE handling below).
  - DONE handling, on the same edge:
    - If pending is valid: pending moves to active, pending clears, idx=0, go to LOAD.
    - Else if i_report_req is high that edge: the new request becomes active directly.
    - Else: go to IDLE.
- Pending-slot ordering: a request arriving on the frame-completion edge while pending is valid is written into pending (now freed). Ordering is preserved.
- Latency: request sampled at edge k gives o_tx_load high after edge k+1, if i_tx_ready was high.
- o_tx_data holds its last value between loads.
- o_busy = active valid OR pending valid.
- Arithmetic: idx is 3 bits. ASCII offsets are 8-bit adds with no overflow (max 8'h37).

Decomposition:
- Package uart_status_pkg:
  - state enum (IDLE, LOAD, WAIT_LOW, WAIT_HIGH)
  - FRAME_LEN=5
  - ASCII_BASE=8'h30
  - report-record struct {ok, gen_num, updown, periods}
- One natural sub-module: status_frame_slot. It is the 2-entry active/pending record buffer with push/pop/drop outputs. The FSM and byte mux stay in the top module.

Test Plan:
1. Reset, then one request with ok=1, gen=3, updown=0, periods=8'h05, i_tx_ready=1. The UART model drops ready 1 cycle after each load and restores it 10 cycles later. Required: bytes 41,33,30,05,0A in order; each o_tx_load exactly 1 cycle wide; first load 1 cycle after the request.
2. ok=0, gen=7, updown=1, periods=8'hFF. Required: bytes 45,37,31,FF,0A.
3. Three requests 2 cycles apart while the first frame is sending. Required: two frames sent in order; o_drop_count=1; o_busy high until the second frame's TERM_CHAR is accepted.
4. UART model keeps i_tx_ready high and never drops it. Required: each byte advances after ACCEPT_TIMEOUT cycles; the frame completes; no load is repeated.
5. Assert i_rst_n=0 during byte 2. Required: o_tx_load, o_busy, and o_drop_count go to 0 asynchronously. After release, a new request sends a full fresh frame starting at byte 0.
6. Request arrives on the completion edge of a frame with pending empty. Required: the new frame's first load follows with no IDLE gap. Then issue 300 back-to-back requests under a stalled UART. Required: o_drop_count saturates at 255.
